// File: rtl/aes_avalon_sequencer.sv
// AES peripheral sequencer: takes a key/ciphertext command from a client,
// drives the peripheral's Avalon-MM slave (key, message, START, DONE polling,
// plaintext readback, START clear) and returns the plaintext on a
// valid/ready result port. READ_LAT must be at least 1.
module aes_avalon_sequencer #(
  parameter int POLL_MAX = 1024,
  parameter int READ_LAT = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CMD_VALID,
  output logic         CMD_READY,
  input  logic         CMD_LOAD_KEY,
  input  logic [127:0] CMD_KEY,
  input  logic [127:0] CMD_MSG,
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic [127:0] RES_DATA,
  output logic         RES_ERR,
  output logic         AVL_CS,
  output logic         AVL_READ,
  output logic         AVL_WRITE,
  output logic [3:0]   AVL_BYTE_EN,
  output logic [3:0]   AVL_ADDR,
  output logic [31:0]  AVL_WRITEDATA,
  input  logic [31:0]  AVL_READDATA
);

  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT - 1);
  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_KEY, S_WR_MSG, S_WR_START, S_POLL_RD, S_POLL_WAIT,
    S_RD_MSG, S_RD_WAIT, S_CLR, S_CLR_ERR, S_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [LW-1:0] lat_cnt, lat_cnt_nxt;
  logic [15:0]   poll_cnt, poll_cnt_nxt;
  logic [127:0]  key, key_nxt;
  logic [127:0]  msg, msg_nxt;
  logic [127:0]  res_data_nxt;
  logic          res_err_nxt;
  logic          cs_nxt, rd_nxt, wr_nxt;
  logic [3:0]    addr_nxt;
  logic [31:0]   wdata_nxt;

  // 32-bit word i of a 128-bit block, word 0 being the most significant
  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
    case (i)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  // Next-state logic: sequencing, word/latency/poll counters, result capture
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    lat_cnt_nxt  = lat_cnt;
    poll_cnt_nxt = poll_cnt;
    key_nxt      = key;
    msg_nxt      = msg;
    res_data_nxt = RES_DATA;
    res_err_nxt  = RES_ERR;
    case (state)
      S_IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          key_nxt      = CMD_KEY;
          msg_nxt      = CMD_MSG;
          poll_cnt_nxt = 16'd0;
          idx_nxt      = 2'd0;
          state_nxt    = CMD_LOAD_KEY ? S_WR_KEY : S_WR_MSG;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WR_KEY: begin
        if (idx == 2'd3) begin
          idx_nxt   = 2'd0;
          state_nxt = S_WR_MSG;
        end else begin
          idx_nxt = idx + 2'd1;
        end
      end
      S_WR_MSG: begin
        if (idx == 2'd3) begin
          idx_nxt   = 2'd0;
          state_nxt = S_WR_START;
        end else begin
          idx_nxt = idx + 2'd1;
        end
      end
      S_WR_START: state_nxt = S_POLL_RD;
      S_POLL_RD: begin
        poll_cnt_nxt = poll_cnt + 16'd1;
        lat_cnt_nxt  = LW'(0);
        state_nxt    = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          if (AVL_READDATA[0]) begin
            idx_nxt   = 2'd0;
            state_nxt = S_RD_MSG;
          end else if (poll_cnt < POLL_LIMIT) begin
            state_nxt = S_POLL_RD;
          end else begin
            state_nxt = S_CLR_ERR;
          end
        end else begin
          lat_cnt_nxt = lat_cnt + LW'(1);
        end
      end
      S_RD_MSG: begin
        lat_cnt_nxt = LW'(0);
        state_nxt   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          case (idx)
            2'd0:    res_data_nxt[127:96] = AVL_READDATA;
            2'd1:    res_data_nxt[95:64]  = AVL_READDATA;
            2'd2:    res_data_nxt[63:32]  = AVL_READDATA;
            default: res_data_nxt[31:0]   = AVL_READDATA;
          endcase
          if (idx == 2'd3) begin
            state_nxt = S_CLR;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = S_RD_MSG;
          end
        end else begin
          lat_cnt_nxt = lat_cnt + LW'(1);
        end
      end
      S_CLR: begin
        res_err_nxt = 1'b0;
        state_nxt   = S_RESP;
      end
      S_CLR_ERR: begin
        res_err_nxt  = 1'b1;
        res_data_nxt = 128'd0;
        state_nxt    = S_RESP;
      end
      S_RESP: begin
        if (RES_READY) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RESP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus cycle for the upcoming state, so the registered strobes line up with it
  always_comb begin
    cs_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    addr_nxt  = 4'd0;
    wdata_nxt = 32'd0;
    case (state_nxt)
      S_WR_KEY: begin
        cs_nxt    = 1'b1;
        wr_nxt    = 1'b1;
        addr_nxt  = {2'b00, idx_nxt};
        wdata_nxt = word_of(key_nxt, idx_nxt);
      end
      S_WR_MSG: begin
        cs_nxt    = 1'b1;
        wr_nxt    = 1'b1;
        addr_nxt  = {2'b01, idx_nxt};
        wdata_nxt = word_of(msg_nxt, idx_nxt);
      end
      S_WR_START: begin
        cs_nxt    = 1'b1;
        wr_nxt    = 1'b1;
        addr_nxt  = 4'd14;
        wdata_nxt = 32'd1;
      end
      S_POLL_RD: begin
        cs_nxt   = 1'b1;
        rd_nxt   = 1'b1;
        addr_nxt = 4'd15;
      end
      S_RD_MSG: begin
        cs_nxt   = 1'b1;
        rd_nxt   = 1'b1;
        addr_nxt = {2'b10, idx_nxt};
      end
      S_CLR, S_CLR_ERR: begin
        cs_nxt    = 1'b1;
        wr_nxt    = 1'b1;
        addr_nxt  = 4'd14;
        wdata_nxt = 32'd0;
      end
      default: begin
        cs_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset idles the bus immediately
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= S_IDLE;
      idx           <= 2'd0;
      lat_cnt       <= LW'(0);
      poll_cnt      <= 16'd0;
      key           <= 128'd0;
      msg           <= 128'd0;
      CMD_READY     <= 1'b0;
      RES_VALID     <= 1'b0;
      RES_DATA      <= 128'd0;
      RES_ERR       <= 1'b0;
      AVL_CS        <= 1'b0;
      AVL_READ      <= 1'b0;
      AVL_WRITE     <= 1'b0;
      AVL_BYTE_EN   <= 4'b0000;
      AVL_ADDR      <= 4'd0;
      AVL_WRITEDATA <= 32'd0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      lat_cnt       <= lat_cnt_nxt;
      poll_cnt      <= poll_cnt_nxt;
      key           <= key_nxt;
      msg           <= msg_nxt;
      CMD_READY     <= (state_nxt == S_IDLE);
      RES_VALID     <= (state_nxt == S_RESP);
      RES_DATA      <= res_data_nxt;
      RES_ERR       <= res_err_nxt;
      AVL_CS        <= cs_nxt;
      AVL_READ      <= rd_nxt;
      AVL_WRITE     <= wr_nxt;
      AVL_BYTE_EN   <= cs_nxt ? 4'b1111 : 4'b0000;
      AVL_ADDR      <= addr_nxt;
      AVL_WRITEDATA <= wdata_nxt;
    end
  end

endmodule
